handshake_monitor: RTL and testbench

HANDSHAKE_MONITOR -- requirements
Module: handshake_monitor

---
 rtl/handshake_monitor.sv | 178 +++++++++++++++++
 tb/tb_handshake_monitor.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_monitor.sv
// handshake_monitor: passive checker for NUM_CH independent ready/valid channels.
// Each channel tracks an IDLE/STALL protocol state, holds the stalled payload and
// counts stall cycles. It raises sticky error flags for three conditions:
// valid dropped before transfer, payload changed while stalled, and stall reaching
// TIMEOUT. It also keeps saturating per-channel transfer counts.
//
// Ports:
//   CLK             clock, all state updates on the rising edge
//   RESETN          synchronous active-low reset (overrides everything)
//   ch_valid        [NUM_CH]            per-channel valid (observed only)
//   ch_ready        [NUM_CH]            per-channel ready (observed only)
//   ch_data         [NUM_CH*DATA_WIDTH] payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clear           synchronous clear of transfer counts and error flags
//   err_valid_drop  [NUM_CH]            sticky: valid deasserted while stalled
//   err_data_change [NUM_CH]            sticky: payload changed while stalled
//   err_timeout     [NUM_CH]            sticky: stall length reached TIMEOUT
//   err_any         OR of all flags (combinational from the flag registers)
//   xfer_count      [NUM_CH*CNT_WIDTH]  saturating completed-transfer counts
//
// Build option: define HANDSHAKE_MONITOR_ASSERT_EN to compile concurrent
// assertions that fire on the same three error events.
module handshake_monitor #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH-1:0]              ch_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    input  logic                           clear,
    output logic [NUM_CH-1:0]              err_valid_drop,
    output logic [NUM_CH-1:0]              err_data_change,
    output logic [NUM_CH-1:0]              err_timeout,
    output logic                           err_any,
    output logic [NUM_CH*CNT_WIDTH-1:0]    xfer_count
);

    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

    localparam logic [STALL_W-1:0]   STALL_ONE = STALL_W'(1);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(TIMEOUT);
    localparam logic [STALL_W-1:0]   STALL_PRE = STALL_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Per-channel registered state
    state_t                 state_q [NUM_CH];
    logic [DATA_WIDTH-1:0]  hold_q  [NUM_CH];
    logic [STALL_W-1:0]     stall_q [NUM_CH];
    logic [CNT_WIDTH-1:0]   cnt_q   [NUM_CH];

    // Next-state values
    state_t                 state_d [NUM_CH];
    logic [DATA_WIDTH-1:0]  hold_d  [NUM_CH];
    logic [STALL_W-1:0]     stall_d [NUM_CH];
    logic [CNT_WIDTH-1:0]   cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]      drop_d;
    logic [NUM_CH-1:0]      chg_d;
    logic [NUM_CH-1:0]      to_d;

    // Single-cycle protocol events
    logic [NUM_CH-1:0]      xfer_ev;
    logic [NUM_CH-1:0]      drop_ev;
    logic [NUM_CH-1:0]      chg_ev;
    logic [NUM_CH-1:0]      to_ev;

    logic [DATA_WIDTH-1:0]  data_cur;
    logic [CNT_WIDTH-1:0]   cnt_base;

    // State register: reset wins over clear and all channel activity
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= ST_IDLE;
                hold_q[i]  <= '0;
                stall_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            err_valid_drop  <= '0;
            err_data_change <= '0;
            err_timeout     <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                stall_q[i] <= stall_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            err_valid_drop  <= drop_d;
            err_data_change <= chg_d;
            err_timeout     <= to_d;
        end
    end

    // Next-state, event detection, flag and counter update
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            stall_d[i] = stall_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        drop_ev  = '0;
        chg_ev   = '0;
        to_ev    = '0;
        xfer_ev  = ch_valid & ch_ready;
        data_cur = '0;
        cnt_base = '0;

        for (int i = 0; i < int'(NUM_CH); i++) begin
            data_cur = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            case (state_q[i])
                ST_IDLE: begin
                    if (ch_valid[i] && !ch_ready[i]) begin
                        state_d[i] = ST_STALL;
                        hold_d[i]  = data_cur;
                        stall_d[i] = STALL_ONE;
                    end
                end
                ST_STALL: begin
                    if (!ch_valid[i]) begin
                        drop_ev[i] = 1'b1;
                        state_d[i] = ST_IDLE;
                        stall_d[i] = '0;
                    end else begin
                        // Payload must stay stable through the completing cycle too
                        chg_ev[i] = (data_cur != hold_q[i]);
                        if (ch_ready[i]) begin
                            state_d[i] = ST_IDLE;
                            stall_d[i] = '0;
                        end else if (stall_q[i] != STALL_MAX) begin
                            // Saturating at TIMEOUT makes the threshold crossing a one-shot per stall
                            stall_d[i] = stall_q[i] + STALL_ONE;
                            to_ev[i]   = (stall_q[i] == STALL_PRE);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            // Clear first, then apply this cycle's transfer on top
            cnt_base = clear ? '0 : cnt_q[i];
            cnt_d[i] = (xfer_ev[i] && (cnt_base != CNT_MAX)) ? cnt_base + CNT_ONE : cnt_base;
        end

        drop_d = (clear ? '0 : err_valid_drop)  | drop_ev;
        chg_d  = (clear ? '0 : err_data_change) | chg_ev;
        to_d   = (clear ? '0 : err_timeout)     | to_ev;
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_count_out
        assign xfer_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

    assign err_any = |{err_valid_drop, err_data_change, err_timeout};

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_assert
        a_valid_drop: assert property (@(posedge CLK) disable iff (!RESETN) !drop_ev[g])
            else $error("handshake_monitor: valid dropped while stalled on channel %0d", g);
        a_data_change: assert property (@(posedge CLK) disable iff (!RESETN) !chg_ev[g])
            else $error("handshake_monitor: payload changed while stalled on channel %0d", g);
        a_timeout: assert property (@(posedge CLK) disable iff (!RESETN) !to_ev[g])
            else $error("handshake_monitor: stall timeout on channel %0d", g);
    end
`endif

endmodule

// File: tb/tb_handshake_monitor.sv
// Bench for handshake_monitor: two instances (16-bit and 2-bit transfer counters)
// driven by identical stimulus and checked every cycle against a cycle-level
// protocol model built from the channel rules.
module tb_handshake_monitor;

    localparam int unsigned NCH = 3;
    localparam int unsigned DW  = 4;
    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 16;
    localparam int unsigned CWS = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 RESETN;
    logic [NCH-1:0]       ch_valid;
    logic [NCH-1:0]       ch_ready;
    logic [NCH*DW-1:0]    ch_data;
    logic                 clear;

    logic [NCH-1:0]       err_valid_drop, err_data_change, err_timeout;
    logic                 err_any;
    logic [NCH*CW-1:0]    xfer_count;
    logic [NCH-1:0]       s_valid_drop, s_data_change, s_timeout;
    logic                 s_any;
    logic [NCH*CWS-1:0]   s_count;

    handshake_monitor #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RESETN(RESETN), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_data(ch_data), .clear(clear), .err_valid_drop(err_valid_drop),
        .err_data_change(err_data_change), .err_timeout(err_timeout),
        .err_any(err_any), .xfer_count(xfer_count)
    );

    handshake_monitor #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CWS)) dut_sat (
        .CLK(CLK), .RESETN(RESETN), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_data(ch_data), .clear(clear), .err_valid_drop(s_valid_drop),
        .err_data_change(s_data_change), .err_timeout(s_timeout),
        .err_any(s_any), .xfer_count(s_count)
    );

    localparam int unsigned AW = 3*NCH + 1 + NCH*CW + 3*NCH + 1 + NCH*CWS;

    logic [AW-1:0] act_all;
    logic [AW-1:0] exp_all;
    assign act_all = {err_valid_drop, err_data_change, err_timeout, err_any, xfer_count,
                      s_valid_drop, s_data_change, s_timeout, s_any, s_count};

    // Protocol model: plain integers describing each channel's situation
    bit m_stalled [NCH];
    int m_hold    [NCH];
    int m_len     [NCH];
    int m_xfers   [NCH];
    int m_xfers_s [NCH];
    bit m_drop    [NCH];
    bit m_chg     [NCH];
    bit m_to      [NCH];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_build();
        logic [NCH-1:0]    e_drop, e_chg, e_to;
        logic [NCH*CW-1:0] e_cnt;
        logic [NCH*CWS-1:0] e_cs;
        logic              e_any;
        for (int c = 0; c < int'(NCH); c++) begin
            e_drop[c] = m_drop[c];
            e_chg[c]  = m_chg[c];
            e_to[c]   = m_to[c];
            e_cnt[c*CW +: CW]   = CW'(m_xfers[c]);
            e_cs[c*CWS +: CWS]  = CWS'(m_xfers_s[c]);
        end
        e_any   = |{e_drop, e_chg, e_to};
        exp_all = {e_drop, e_chg, e_to, e_any, e_cnt, e_drop, e_chg, e_to, e_any, e_cs};
    endtask

    // Advance one clock: the model consumes the same inputs the DUT sampled
    task automatic step();
        bit v, r;
        int d;
        @(posedge CLK);
        for (int c = 0; c < int'(NCH); c++) begin
            v = ch_valid[c];
            r = ch_ready[c];
            d = int'(ch_data[c*DW +: DW]);
            if (!RESETN) begin
                m_stalled[c] = 0; m_hold[c] = 0; m_len[c] = 0;
                m_xfers[c] = 0; m_xfers_s[c] = 0;
                m_drop[c] = 0; m_chg[c] = 0; m_to[c] = 0;
            end else begin
                if (clear) begin
                    m_xfers[c] = 0; m_xfers_s[c] = 0;
                    m_drop[c] = 0; m_chg[c] = 0; m_to[c] = 0;
                end
                if (v && r) begin
                    if (m_xfers[c] < (1 << CW) - 1)    m_xfers[c]++;
                    if (m_xfers_s[c] < (1 << CWS) - 1) m_xfers_s[c]++;
                end
                if (!m_stalled[c]) begin
                    if (v && !r) begin
                        m_stalled[c] = 1; m_hold[c] = d; m_len[c] = 1;
                    end
                end else if (!v) begin
                    m_drop[c] = 1; m_stalled[c] = 0;
                end else begin
                    if (d != m_hold[c]) m_chg[c] = 1;
                    if (r) m_stalled[c] = 0;
                    else begin
                        m_len[c]++;
                        if (m_len[c] == int'(TO)) m_to[c] = 1;
                    end
                end
            end
        end
        model_build();
        #1;
    endtask

    task automatic drive(input int c, input bit v, input bit r, input int d);
        ch_valid[c] = v;
        ch_ready[c] = r;
        ch_data[c*DW +: DW] = DW'(d);
    endtask

    task automatic idle_all();
        ch_valid = '0;
        ch_ready = '0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ch_valid = NCH'($urandom);
            ch_ready = NCH'($urandom);
            ch_data  = (NCH*DW)'($urandom);
            clear    = 1'($urandom);
            step();
            n_tests++;
            if (act_all !== '0) begin
                n_fail++;
                $display("FAIL reset_zero cyc%0d got %h want 0", k, act_all);
            end
        end
        idle_all();
        RESETN = 1'b1;
        step();
        n_tests++;
        if (act_all !== exp_all || act_all !== '0) begin
            n_fail++;
            $display("FAIL reset_release got %h want %h", act_all, exp_all);
        end
    endtask

    task automatic test_basic();
        drive(0, 1, 0, 5);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) drive(0, 1, 1, 5);
            if (k == 4) drive(0, 0, 0, 5);
            step();
            n_tests++;
            if (act_all !== exp_all) begin
                n_fail++;
                $display("FAIL basic cyc%0d got %h want %h", k, act_all, exp_all);
            end
        end
        n_tests++;
        if (xfer_count[CW-1:0] !== 16'd1 || err_any !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count got cnt=%0d any=%b want cnt=1 any=0", xfer_count[CW-1:0], err_any);
        end
    endtask

    task automatic test_data_change();
        drive(1, 1, 0, 3);
        step();
        drive(1, 1, 0, 7);
        step();
        n_tests++;
        if (err_data_change[1] !== 1'b1 || err_any !== 1'b1 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL data_change got %h want %h", act_all, exp_all);
        end
        drive(1, 1, 1, 7);
        step();
        drive(1, 0, 0, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_tests++;
        if (act_all !== exp_all || err_any !== 1'b0) begin
            n_fail++;
            $display("FAIL data_change_clear got %h want %h", act_all, exp_all);
        end
    endtask

    task automatic test_valid_drop();
        drive(2, 1, 0, 9);
        for (int k = 0; k < 3; k++) step();
        drive(2, 0, 0, 9);
        step();
        n_tests++;
        if (err_valid_drop[2] !== 1'b1 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL valid_drop got %h want %h", act_all, exp_all);
        end
        // Back in IDLE: a new payload must not be compared with the old one
        drive(2, 1, 1, 2);
        step();
        n_tests++;
        if (err_data_change[2] !== 1'b0 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL drop_to_idle got %h want %h", act_all, exp_all);
        end
        drive(2, 0, 0, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_timeout();
        drive(0, 1, 0, 10);
        for (int k = 1; k <= 20; k++) begin
            step();
            n_tests++;
            if (act_all !== exp_all || err_timeout[0] !== (k >= int'(TO))) begin
                n_fail++;
                $display("FAIL timeout cyc%0d got %h want %h", k, act_all, exp_all);
            end
        end
        // Clear during the same long stall: the threshold was already crossed
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_tests++;
            if (err_timeout[0] !== 1'b0 || act_all !== exp_all) begin
                n_fail++;
                $display("FAIL timeout_once cyc%0d got %h want %h", k, act_all, exp_all);
            end
        end
        drive(0, 1, 1, 10);
        step();
        drive(0, 0, 0, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 1, int'($urandom_range(0, 15)));
            step();
        end
        drive(0, 0, 0, 0);
        step();
        n_tests++;
        if (s_count[CWS-1:0] !== 2'd3 || xfer_count[CW-1:0] !== 16'd5 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL saturation got sat=%0d full=%0d want 3 and 5", s_count[CWS-1:0], xfer_count[CW-1:0]);
        end
    endtask

    task automatic test_clear_xfer();
        drive(1, 1, 1, 4);
        for (int k = 0; k < 3; k++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(1, 0, 0, 0);
        n_tests++;
        if (xfer_count[CW +: CW] !== 16'd1 || xfer_count[CW-1:0] !== 16'd0 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL clear_xfer got %h want %h", act_all, exp_all);
        end
        // Clear must not disturb a stall in progress
        drive(0, 1, 0, 6);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(0, 1, 1, 6);
        step();
        drive(0, 0, 0, 0);
        n_tests++;
        if (err_any !== 1'b0 || xfer_count[CW-1:0] !== 16'd1 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL clear_keeps_stall got %h want %h", act_all, exp_all);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(2, 1, 0, 4);
        for (int k = 0; k < 3; k++) step();
        drive(2, 0, 0, 4);
        RESETN = 1'b0;
        step();
        n_tests++;
        if (act_all !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall got %h want 0", act_all);
        end
        RESETN = 1'b1;
        step();
        n_tests++;
        if (act_all !== '0 || act_all !== exp_all) begin
            n_fail++;
            $display("FAIL reset_no_flag got %h want 0", act_all);
        end
    endtask

    task automatic test_random();
        bit slow;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) slow = ($urandom_range(0, 1) == 1);
            RESETN = ($urandom_range(0, 399) != 0);
            clear  = ($urandom_range(0, 149) == 0);
            for (int c = 0; c < int'(NCH); c++) begin
                ch_valid[c] = ($urandom_range(0, 5) != 0);
                ch_ready[c] = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 7) == 0)
                    ch_data[c*DW +: DW] = DW'($urandom);
            end
            step();
            n_tests++;
            if (act_all !== exp_all) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h want %h", k, act_all, exp_all);
            end
        end
        RESETN = 1'b1;
        idle_all();
    endtask

    initial begin
        ch_data = '0;
        idle_all();
        RESETN = 1'b0;
        test_reset();
        test_basic();
        test_data_change();
        test_valid_drop();
        test_timeout();
        test_saturation();
        test_clear_xfer();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
